// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared geometry and FSM encoding for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    // Default line count is 2**c_INDEX_BITS; one 32-bit word per line.
    localparam int c_INDEX_BITS = 6;
    localparam int c_TAG_BITS   = 30 - c_INDEX_BITS;
    localparam int c_BYTE_LANES = 4;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MISS  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    function automatic int tag_bits(input int index_bits);
        return 30 - index_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Direct-mapped tag/valid/data storage, combinational read,
//               single write port, synchronous valid clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_INDEX_BITS,
    parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [31:0]           i_wr_data
);

    localparam int c_LINES = 1 << INDEX_BITS;

    logic [c_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag  [c_LINES];
    logic [31:0]         r_data [c_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped one-word-per-line instruction cache with a
//               byte-serial miss fill and flush/drain handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        RoB_clear,
    input  logic [31:0] fetch_addr,
    output logic        ready_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_byte_valid,
    input  logic [7:0]  mc_byte
);

    localparam int c_TAGW = tag_bits(INDEX_BITS);
    localparam logic [1:0] c_LAST_LANE = 2'(c_BYTE_LANES - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_ready;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic        r_mc_req;
    logic [31:0] r_mc_addr;

    logic                  w_rd_valid;
    logic [c_TAGW-1:0]     w_rd_tag;
    logic [31:0]           w_rd_data;
    logic                  w_hit;
    logic [31:0]           w_fetch_word;
    logic                  w_last_byte;
    logic                  w_wr_en;
    logic [31:0]           w_fill_word;
    logic                  w_unused_ok;

    assign w_fetch_word = {fetch_addr[31:2], 2'b00};
    assign w_unused_ok  = ^fetch_addr[1:0];
    assign w_hit        = w_rd_valid && (w_rd_tag == fetch_addr[31:INDEX_BITS+2]);
    assign w_last_byte  = mc_byte_valid && (r_cnt == c_LAST_LANE);
    assign w_fill_word  = {mc_byte, r_word[23:0]};
    // A flush on the final byte still commits the line: the data is complete.
    assign w_wr_en      = rdy_in && !rst_in && (r_state == c_MISS) && w_last_byte;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (c_TAGW)
    ) u_array (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_rd_index (fetch_addr[INDEX_BITS+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_mc_addr[INDEX_BITS+1:2]),
        .i_wr_tag   (r_mc_addr[31:INDEX_BITS+2]),
        .i_wr_data  (w_fill_word)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            r_word      <= 32'd0;
            r_ready     <= 1'b0;
            r_inst      <= 32'd0;
            r_inst_addr <= 32'd0;
            r_mc_req    <= 1'b0;
            r_mc_addr   <= 32'd0;
        end else if (rdy_in) begin
            r_ready <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!RoB_clear) begin
                        if (w_hit) begin
                            r_ready     <= 1'b1;
                            r_inst      <= w_rd_data;
                            r_inst_addr <= w_fetch_word;
                        end else begin
                            r_mc_req  <= 1'b1;
                            r_mc_addr <= w_fetch_word;
                            r_cnt     <= 2'd0;
                            r_state   <= c_MISS;
                        end
                    end
                end
                c_MISS: begin
                    if (mc_byte_valid) begin
                        r_word[r_cnt*8 +: 8] <= mc_byte;
                        r_cnt                <= r_cnt + 2'd1;
                    end
                    if (w_last_byte) begin
                        r_mc_req <= 1'b0;
                        r_state  <= c_IDLE;
                        if (!RoB_clear) begin
                            r_ready     <= 1'b1;
                            r_inst      <= w_fill_word;
                            r_inst_addr <= r_mc_addr;
                        end
                    end else if (RoB_clear) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Arbiter always returns all four bytes; swallow the rest.
                    if (mc_byte_valid) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                    if (w_last_byte) begin
                        r_mc_req <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_mc_req <= 1'b0;
                    r_cnt    <= 2'd0;
                end
            endcase
        end
    end

    assign ready_out     = r_ready;
    assign inst_out      = r_inst;
    assign inst_addr_out = r_inst_addr;
    assign mc_req        = r_mc_req;
    assign mc_addr       = r_mc_addr;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module      : tb_icache
// Description : Directed self-checking bench for icache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [31:0] faddr;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic        req;
    logic [31:0] maddr;
    logic        bv;
    logic [7:0]  bdat;

    int n_total = 0;
    int n_bad   = 0;

    icache u_dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .RoB_clear     (clr),
        .fetch_addr    (faddr),
        .ready_out     (ready),
        .inst_out      (inst),
        .inst_addr_out (iaddr),
        .mc_req        (req),
        .mc_addr       (maddr),
        .mc_byte_valid (bv),
        .mc_byte       (bdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bv   = 1'b1;
        bdat = b;
        tick();
        bv   = 1'b0;
        bdat = 8'h00;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic expect_out(input string tag, input logic r, input logic [31:0] d,
                              input logic [31:0] a, input logic q);
        chk({tag, ".ready"}, {31'd0, ready}, {31'd0, r});
        if (r) begin
            chk({tag, ".inst"}, inst, d);
            chk({tag, ".iaddr"}, iaddr, a);
        end
        chk({tag, ".req"}, {31'd0, req}, {31'd0, q});
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; faddr = 32'h0; bv = 1'b0; bdat = 8'h0;
        tick(); tick();
        chk("rst.ready", {31'd0, ready}, 32'd0);
        chk("rst.inst",  inst,  32'd0);
        chk("rst.iaddr", iaddr, 32'd0);
        chk("rst.req",   {31'd0, req}, 32'd0);
        chk("rst.maddr", maddr, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x0
        tick();
        expect_out("cold.req", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("cold.maddr", maddr, 32'h0);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
        chk("cold.partial", {31'd0, ready}, 32'd0);
        send_byte(8'h00);
        expect_out("cold.done", 1'b1, 32'h00100513, 32'h0, 1'b0);

        // Back-to-back hits, including a misaligned address
        faddr = 32'h0; tick();
        expect_out("hit0", 1'b1, 32'h00100513, 32'h0, 1'b0);
        faddr = 32'h2; tick();
        expect_out("hit2", 1'b1, 32'h00100513, 32'h0, 1'b0);

        // Conflict at index 1
        faddr = 32'h4; tick();
        expect_out("miss4", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("miss4.maddr", maddr, 32'h4);
        fill(32'h00000093);
        expect_out("fill4", 1'b1, 32'h00000093, 32'h4, 1'b0);
        faddr = 32'h104; tick();
        expect_out("miss104", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("miss104.maddr", maddr, 32'h104);
        fill(32'h000002B7);
        expect_out("fill104", 1'b1, 32'h000002B7, 32'h104, 1'b0);
        faddr = 32'h4; tick();
        expect_out("remiss4", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("remiss4.maddr", maddr, 32'h4);
        fill(32'h00000093);
        expect_out("refill4", 1'b1, 32'h00000093, 32'h4, 1'b0);

        // Flush after two bytes: drain, no delivery, line not written
        faddr = 32'h40; tick();
        chk("fl.maddr", maddr, 32'h40);
        send_byte(8'h11); send_byte(8'h22);
        clr = 1'b1; tick(); clr = 1'b0;
        expect_out("fl.clr", 1'b0, 32'h0, 32'h0, 1'b1);
        send_byte(8'h33);
        expect_out("fl.b3", 1'b0, 32'h0, 32'h0, 1'b1);
        send_byte(8'h44);
        expect_out("fl.b4", 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        expect_out("fl.remiss", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("fl.remiss.maddr", maddr, 32'h40);

        // Freeze mid-miss; a flush and address change while frozen are ignored
        send_byte(8'h33);
        rdy = 1'b0; clr = 1'b1; faddr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("frz", 1'b0, 32'h0, 32'h0, 1'b1);
            chk("frz.maddr", maddr, 32'h40);
        end
        rdy = 1'b1; clr = 1'b0;
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        expect_out("frz.done", 1'b1, 32'h66554433, 32'h40, 1'b0);
        faddr = 32'h40; tick();
        expect_out("hit40", 1'b1, 32'h66554433, 32'h40, 1'b0);

        // Freeze holds a delivered word
        rdy = 1'b0; faddr = 32'h0;
        tick(); tick();
        expect_out("frz.hold", 1'b1, 32'h66554433, 32'h40, 1'b0);
        rdy = 1'b1;

        // Flush in IDLE suppresses a hit
        faddr = 32'h40; clr = 1'b1; tick(); clr = 1'b0;
        expect_out("idle.clr", 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset mid-miss clears every valid bit
        faddr = 32'h0; tick();
        expect_out("prehit0", 1'b1, 32'h00100513, 32'h0, 1'b0);
        faddr = 32'h80; tick();
        chk("rm.maddr", maddr, 32'h80);
        send_byte(8'hAA);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_out("rm.rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rm.inst", inst, 32'h0);
        chk("rm.maddr0", maddr, 32'h0);
        faddr = 32'h0; tick();
        expect_out("rm.miss0", 1'b0, 32'h0, 32'h0, 1'b1);
        chk("rm.miss0.maddr", maddr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache directly upstream of the instruction fetcher.
- Takes the fetcher's registered fetch address and returns a 32-bit instruction with a one-cycle ready strobe. This produces the fetcher's ready_in and inst_in.
- On a miss it reads 4 bytes, little-endian, through the memory arbiter's byte-serial read port, fills the line and delivers the word.
- Aborts delivery on RoB_clear.

Parameters:
- INDEX_BITS, default 6: log2 of line count (64 lines); tag width = 30 - INDEX_BITS.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global ready; low freezes every register
- RoB_clear  in  1  pipeline flush; abandons any in-flight fetch
- fetch_addr  in  32  fetcher's address; bits [1:0] ignored
- ready_out  out  1  registered strobe: inst_out/inst_addr_out valid this cycle
- inst_out  out  32  registered instruction
- inst_addr_out  out  32  word-aligned address inst_out belongs to
- mc_req  out  1  level request to memory arbiter
- mc_addr  out  32  word-aligned miss address, stable while mc_req=1
- mc_byte_valid  in  1  arbiter returns one byte this cycle
- mc_byte  in  8  returned byte, order addr+0..addr+3

Behaviour:
- Reset (rst_in=1 at clock edge), including mid-miss:
  - valid bits cleared; state IDLE.
  - ready_out=0, inst_out=0, inst_addr_out=0, mc_req=0, mc_addr=0, byte counter 0.
  - Tag and data arrays need not be reset.
- rdy_in=0: no register changes; outputs hold. Takes priority below rst_in only.
- Index = fetch_addr[INDEX_BITS+1:2]; tag = fetch_addr[31:INDEX_BITS+2].
- State IDLE, each cycle:
  - Hit (valid & tag match, RoB_clear=0): next cycle ready_out=1, inst_out=line data, inst_addr_out={fetch_addr[31:2],2'b00}.
    - Hit latency is 1 cycle; back-to-back hits give ready_out on consecutive cycles.
  - Miss (RoB_clear=0): next cycle mc_req=1, mc_addr=word-aligned fetch_addr, counter=0, state MISS, ready_out=0.
  - RoB_clear=1: ready_out=0 next cycle; no lookup that cycle.
- State MISS:
  - Each mc_byte_valid stores mc_byte into word byte lane [counter]; counter increments.
  - On the 4th byte: write tag/data/valid for mc_addr's line; mc_req=0 next cycle; state IDLE; next cycle ready_out=1 with the assembled word and inst_addr_out=mc_addr.
  - RoB_clear=1 in MISS: state DRAIN. A byte arriving in the same cycle is counted.
- State DRAIN:
  - mc_req stays 1; arbiter contract is that a started request always returns exactly 4 bytes.
  - Bytes are counted and discarded. No array write, no ready_out.
  - After the 4th byte: mc_req=0, state IDLE.
  - fetch_addr is ignored until IDLE.
- RoB_clear on the cycle the 4th byte arrives in MISS: line is still written (data is correct), ready_out suppressed, state IDLE.
- ready_out is never asserted in the cycle following a RoB_clear.
- mc_req deasserts for at least one cycle between consecutive misses.
- fetch_addr changes while in MISS are ignored. The delivered word is always for mc_addr; the fetcher re-presents its address after a miss.
- Byte counter is 2 bits; wraps to 0 on the 4th byte.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, MISS, DRAIN)
  - INDEX_BITS default and derived TAG_BITS
  - byte-lane count constant (4)
- One natural sub-module: icache_array. Tag/valid/data storage with combinational read by index, single write port, synchronous valid clear on reset.
- FSM and byte assembly stay in the top module.

Test Plan:
- Cold miss: reset, fetch_addr=0x00000000; arbiter returns 0x13,0x05,0x10,0x00 one per cycle -> mc_req=1 with mc_addr=0; one cycle after the 4th byte, ready_out=1, inst_out=0x00100513, inst_addr_out=0; mc_req drops.
- Hit after fill: present 0x00000000 again -> ready_out=1 next cycle with 0x00100513, mc_req stays 0. Present 0x00000002 -> same hit.
- Conflict miss: fill 0x00000004, then fetch 0x00000104 (same index 1, different tag, INDEX_BITS=6) -> miss issued, mc_addr=0x104. Re-fetching 0x004 then misses again.
- Flush mid-miss: RoB_clear after 2 of 4 bytes -> mc_req held until 4 bytes; ready_out never asserted; re-fetching the same address misses (line not written).
- Freeze: rdy_in=0 for 3 cycles during MISS while bytes are withheld -> counter, mc_req and outputs unchanged; resumes correctly when rdy_in=1.
- Reset mid-miss: rst_in=1 after 1 byte -> next cycle mc_req=0, ready_out=0, all valid cleared; prior hit address now misses.
